// File: rtl/nco_pkg.sv
// Shared widths and the quarter-wave sine table for the NCO.
// Table entries are round(127*sin(2*pi*k/256)) for k = 0..64.
package nco_pkg;

    localparam int ACC_W = 16;
    localparam int IDX_W = 8;
    localparam int OUT_W = 8;
    localparam int MAG_W = 7;
    localparam int QTR_N = 65;

    typedef logic [MAG_W-1:0] mag_t;

    localparam mag_t SINE_QTR [0:QTR_N-1] = '{
        7'd0,   7'd3,   7'd6,   7'd9,   7'd12,  7'd16,  7'd19,  7'd22,
        7'd25,  7'd28,  7'd31,  7'd34,  7'd37,  7'd40,  7'd43,  7'd46,
        7'd49,  7'd51,  7'd54,  7'd57,  7'd60,  7'd63,  7'd65,  7'd68,
        7'd71,  7'd73,  7'd76,  7'd78,  7'd81,  7'd83,  7'd85,  7'd88,
        7'd90,  7'd92,  7'd94,  7'd96,  7'd98,  7'd100, 7'd102, 7'd104,
        7'd106, 7'd107, 7'd109, 7'd111, 7'd112, 7'd113, 7'd115, 7'd116,
        7'd117, 7'd118, 7'd120, 7'd121, 7'd122, 7'd122, 7'd123, 7'd124,
        7'd125, 7'd125, 7'd126, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127,
        7'd127
    };

    // Odd quadrants read the table backwards; 64-i reaches the endpoint entry at i=0.
    function automatic logic [MAG_W-1:0] fold_addr(input logic [IDX_W-1:0] p);
        logic [MAG_W-1:0] i_ext;
        i_ext = {1'b0, p[5:0]};
        return p[6] ? (7'd64 - i_ext) : i_ext;
    endfunction

endpackage

// File: rtl/nco_sine_rom.sv
// Combinational quarter-wave magnitude lookup: 6-bit index plus an endpoint
// flag selecting the k=64 entry.
module nco_sine_rom
    import nco_pkg::*;
(
    input  logic [5:0] idx,
    input  logic       endpoint,
    output mag_t       mag
);

    mag_t rom_row [0:QTR_N-2];

    genvar gi;
    generate
        for (gi = 0; gi < QTR_N - 1; gi++) begin : g_row
            assign rom_row[gi] = SINE_QTR[gi];
        end
    endgenerate

    assign mag = endpoint ? SINE_QTR[QTR_N-1] : rom_row[idx];

endmodule

// File: rtl/nco.sv
// Numerically controlled oscillator: 16-bit phase accumulator, quarter-wave
// folding and a three-stage registered pipeline to a signed 8-bit sine sample.
module nco
    import nco_pkg::*;
(
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    input  logic [IDX_W-1:0]        i_data,
    output logic signed [OUT_W-1:0] o_data
);

    logic [ACC_W-1:0] acc_reg;
    logic [IDX_W-1:0] phase_idx;
    logic [MAG_W-1:0] rom_addr;
    mag_t             rom_mag;
    mag_t             mag_reg;
    logic             sign_reg;
    logic signed [OUT_W-1:0] mag_signed;

    assign phase_idx  = acc_reg[ACC_W-1 -: IDX_W];
    assign rom_addr   = fold_addr(phase_idx);
    assign mag_signed = $signed({1'b0, mag_reg});

    nco_sine_rom u_rom (
        .idx      (rom_addr[5:0]),
        .endpoint (rom_addr[6]),
        .mag      (rom_mag)
    );

    // Magnitude never exceeds 127, so the negation cannot produce -128.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            acc_reg  <= '0;
            mag_reg  <= '0;
            sign_reg <= 1'b0;
            o_data   <= '0;
        end else begin
            acc_reg  <= acc_reg + {{(ACC_W-IDX_W){1'b0}}, i_data};
            mag_reg  <= rom_mag;
            sign_reg <= phase_idx[IDX_W-1];
            o_data   <= sign_reg ? -mag_signed : mag_signed;
        end
    end

endmodule

// File: tb/tb_nco.sv
// Directed bench for nco: reset behaviour, frozen phase, full period at FTW=64,
// wrap at FTW=255, phase-continuous retune and mid-run asynchronous reset.
module tb_nco;

    logic              i_clk;
    logic              i_reset_n;
    logic [7:0]        i_data;
    logic signed [7:0] o_data;

    int passes = 0;
    int total  = 0;

    int          lut [0:64];
    logic [15:0] acc_m;
    logic [7:0]  s2_m;
    logic signed [7:0] out_m;

    nco dut (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_data    (i_data),
        .o_data    (o_data)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    function automatic logic signed [7:0] fval(input logic [7:0] p);
        int k;
        k = p[6] ? (64 - int'(p[5:0])) : int'(p[5:0]);
        return p[7] ? 8'(-lut[k]) : 8'(lut[k]);
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0d expected=%0d at t=%0t", tag, obs, exp, $time);
    endtask

    task automatic check_o(input string tag, input logic signed [7:0] exp);
        total++;
        assert (o_data === exp) passes++;
        else $error("FAIL %s observed=%0d expected=%0d at t=%0t", tag, o_data, exp, $time);
    endtask

    // One clock: advance the model on the edge, then compare #1 later.
    task automatic tick();
        @(posedge i_clk);
        if (i_reset_n) begin
            out_m = fval(s2_m);
            s2_m  = acc_m[15:8];
            acc_m = acc_m + {8'h00, i_data};
        end
        #1;
        check_o("o_data", out_m);
        check("acc", dut.acc_reg, acc_m);
        $display("t=%0t rst_n=%0b ftw=%0d p=%0d o_data=%0d", $time, i_reset_n, i_data, acc_m[15:8], o_data);
    endtask

    // Mid-cycle asynchronous assert; outputs must clear without a clock edge.
    task automatic async_reset();
        #3;
        i_reset_n = 1'b0;
        #1;
        acc_m = '0;
        s2_m  = '0;
        out_m = '0;
        check_o("async_rst_o", 8'sd0);
        check("async_rst_acc", dut.acc_reg, 16'd0);
        tick();
        tick();
        #3;
        i_reset_n = 1'b1;
    endtask

    initial begin
        for (int k = 0; k <= 64; k++)
            lut[k] = $rtoi(127.0 * $sin(2.0 * 3.14159265358979 * k / 256.0) + 0.5);
        acc_m = '0;
        s2_m  = '0;
        out_m = '0;

        // Reset held with a toggling tuning word
        i_reset_n = 1'b0;
        i_data    = 8'hFF;
        #2;
        check_o("reset_o", 8'sd0);
        for (int n = 0; n < 6; n++) begin
            i_data = (n % 2 == 0) ? 8'hFF : 8'h00;
            tick();
        end

        // Release with FTW=0: output stays at zero
        i_data = 8'h00;
        #3;
        i_reset_n = 1'b1;
        for (int n = 0; n < 10; n++) tick();
        check_o("ftw0_hold", 8'sd0);

        // FTW=64: one table step per 4 clocks, landmarks two clocks late
        i_data = 8'd64;
        for (int n = 1; n <= 1030; n++) begin
            tick();
            if (n == 130) check_o("p32_is_90", 8'sd90);
            if (n == 258) check_o("p64_is_127", 8'sd127);
            if (n == 514) check_o("p128_is_0", 8'sd0);
            if (n == 770) check_o("p192_is_m127", -8'sd127);
            if (n == 898) check_o("p224_is_m90", -8'sd90);
            if (n == 1026) check_o("period_wrap", 8'sd0);
        end

        // FTW=255 across accumulator wrap
        i_data = 8'd255;
        for (int n = 0; n < 320; n++) tick();

        // Retune 64 -> 128 at p=40
        async_reset();
        i_data = 8'd64;
        for (int n = 1; n <= 160; n++) tick();
        check("retune_p0", dut.acc_reg[15:8], 16'd40);
        i_data = 8'd128;
        tick();
        check("retune_p1", dut.acc_reg[15:8], 16'd40);
        check_o("retune_o161", 8'sd104);
        tick();
        check("retune_p2", dut.acc_reg[15:8], 16'd41);
        check_o("retune_o162", 8'sd106);
        tick();
        check_o("retune_o163", 8'sd106);
        tick();
        check_o("retune_o164", 8'sd107);
        for (int n = 0; n < 20; n++) tick();

        // Asynchronous reset at p=100, then restart identical to a fresh run
        async_reset();
        i_data = 8'd64;
        for (int n = 1; n <= 400; n++) tick();
        check("p100_reached", dut.acc_reg[15:8], 16'd100);
        async_reset();
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (n == 2)  check_o("restart_n2", 8'sd0);
            if (n == 10) check_o("restart_n10", 8'sd6);
            if (n == 30) check_o("restart_n30", 8'sd22);
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
